// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Covers the write-source encoding and the buffered LU result layout.
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_FIFO,
        SRC_LU
    } wr_src_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } lu_result_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding LU results that lost the write port to WB.
// The caller never pushes when full or pops when empty.
module wb_result_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  lu_result_t       wdata,
    output lu_result_t       rdata,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    lu_result_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between pipeline WB and the LU,
// buffering losing LU results and tracking outstanding LU destinations.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned CNT_W      = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WbWre,
    input  logic [REG_ADDR_W-1:0] WbReg,
    input  logic [DATA_W-1:0]     WbData,
    input  logic                  LuValid,
    output logic                  LuReady,
    input  logic [REG_ADDR_W-1:0] LuReg,
    input  logic [DATA_W-1:0]     LuData,
    input  logic                  IssueValid,
    input  logic                  IssueLong,
    input  logic [REG_ADDR_W-1:0] IssueRs,
    input  logic [REG_ADDR_W-1:0] IssueRt,
    input  logic [REG_ADDR_W-1:0] IssueRd,
    output logic                  Stall,
    output logic                  RegWre,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0]     WriteData,
    output logic [31:0]           Pending,
    output logic [CNT_W-1:0]      FifoCount
);

    wr_src_e          src;
    lu_result_t       fifo_head;
    lu_result_t       lu_result;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_push;
    logic             fifo_pop;
    logic             lu_xfer;
    logic             wb_active;
    logic             issue_set;
    logic             retire_clr;
    logic [31:0]      pending_q, pending_d;

    assign lu_result  = '{rd: LuReg, data: LuData};
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign LuReady    = RST && !fifo_full;
    assign lu_xfer    = LuValid && LuReady;
    assign wb_active  = WbWre && (WbReg != REG_ZERO);

    // Buffered results always drain before a fresh LU result may bypass.
    always_comb begin
        src = SRC_NONE;
        if (wb_active) begin
            src = SRC_WB;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end else if (lu_xfer) begin
            src = SRC_LU;
        end
    end

    assign fifo_push = lu_xfer && ((src == SRC_WB) || (src == SRC_FIFO));
    assign fifo_pop  = (src == SRC_FIFO);

    always_comb begin
        WriteReg  = REG_ZERO;
        WriteData = '0;
        unique case (src)
            SRC_WB: begin
                WriteReg  = WbReg;
                WriteData = WbData;
            end
            SRC_FIFO: begin
                WriteReg  = fifo_head.rd;
                WriteData = fifo_head.data;
            end
            SRC_LU: begin
                WriteReg  = LuReg;
                WriteData = LuData;
            end
            default: ;
        endcase
    end

    // LU results addressed to r0 occupy their slot but never write.
    assign RegWre = RST && (src != SRC_NONE) && (WriteReg != REG_ZERO);

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (lu_result),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    assign Stall = RST && IssueValid &&
                   (pending_q[IssueRs] || pending_q[IssueRt] || pending_q[IssueRd] ||
                    (IssueLong && fifo_full));

    assign issue_set  = IssueValid && IssueLong && !Stall && (IssueRd != REG_ZERO);
    assign retire_clr = (src == SRC_FIFO) || (src == SRC_LU);

    always_comb begin
        pending_d = pending_q;
        if (retire_clr) begin
            pending_d[WriteReg] = 1'b0;
        end
        if (issue_set) begin
            pending_d[IssueRd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign Pending   = pending_q;
    assign FifoCount = fifo_count;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic checked against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic        CLK;
    logic        RST;
    logic        WbWre;
    logic [4:0]  WbReg;
    logic [31:0] WbData;
    logic        LuValid;
    logic        LuReady;
    logic [4:0]  LuReg;
    logic [31:0] LuData;
    logic        IssueValid;
    logic        IssueLong;
    logic [4:0]  IssueRs;
    logic [4:0]  IssueRt;
    logic [4:0]  IssueRd;
    logic        Stall;
    logic        RegWre;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] Pending;
    logic [CW-1:0] FifoCount;

    regfile_wb_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WbWre      (WbWre),
        .WbReg      (WbReg),
        .WbData     (WbData),
        .LuValid    (LuValid),
        .LuReady    (LuReady),
        .LuReg      (LuReg),
        .LuData     (LuData),
        .IssueValid (IssueValid),
        .IssueLong  (IssueLong),
        .IssueRs    (IssueRs),
        .IssueRt    (IssueRt),
        .IssueRd    (IssueRd),
        .Stall      (Stall),
        .RegWre     (RegWre),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .Pending    (Pending),
        .FifoCount  (FifoCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buffered LU results in acceptance order and a pending set.
    logic [36:0] mq[$];
    logic [31:0] pend_m;
    bit          last_xfer;
    bit          last_fire;
    logic [4:0]  lu_out[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            assert (!(WbWre && WbReg != 5'd0 && Pending[WbReg]))
            else begin
                n_fail++;
                $error("FAIL wb_to_pending: WbReg=%0d is pending", WbReg);
            end
        end
    end

    task automatic idle_inputs();
        WbWre = 0; WbReg = 0; WbData = 0;
        LuValid = 0; LuReg = 0; LuData = 0;
        IssueValid = 0; IssueLong = 0; IssueRs = 0; IssueRt = 0; IssueRd = 0;
    endtask

    task automatic model_reset();
        mq.delete();
        lu_out.delete();
        pend_m = '0;
    endtask

    task automatic reset_check();
        check("rst_ready", LuReady, 0);
        check("rst_count", FifoCount, 0);
        check("rst_pending", Pending, 0);
        check("rst_regwre", RegWre, 0);
        check("rst_stall", Stall, 0);
    endtask

    // Check one cycle's outputs against the model, then advance across the edge.
    task automatic step();
        int          cnt;
        bit          exp_ready, xfer, exp_stall, exp_we, bypass, pop;
        logic [4:0]  exp_reg, clr;
        logic [31:0] exp_data;
        #1;
        cnt       = mq.size();
        exp_ready = (cnt < DEPTH);
        xfer      = LuValid && exp_ready;
        exp_stall = IssueValid && (pend_m[IssueRs] || pend_m[IssueRt] || pend_m[IssueRd] ||
                                   (IssueLong && cnt == DEPTH));
        exp_we = 0; exp_reg = 0; exp_data = 0; bypass = 0; pop = 0; clr = 0;
        if (WbWre && WbReg != 0) begin
            exp_we = 1; exp_reg = WbReg; exp_data = WbData;
        end else if (cnt > 0) begin
            {exp_reg, exp_data} = mq[0];
            exp_we = (exp_reg != 0); pop = 1; clr = exp_reg;
        end else if (xfer) begin
            exp_reg = LuReg; exp_data = LuData;
            exp_we = (LuReg != 0); bypass = 1; clr = LuReg;
        end
        check("lu_ready", LuReady, exp_ready);
        check("fifo_count", FifoCount, cnt);
        check("stall", Stall, exp_stall);
        check("pending", Pending, pend_m);
        check("reg_wre", RegWre, exp_we);
        if (exp_we) begin
            check("write_reg", WriteReg, exp_reg);
            check("write_data", WriteData, exp_data);
        end
        last_xfer = xfer;
        last_fire = IssueValid && IssueLong && !exp_stall && IssueRd != 0;
        @(posedge CLK);
        if (pop) void'(mq.pop_front());
        if (xfer && !bypass) mq.push_back({LuReg, LuData});
        if (clr != 0) pend_m[clr] = 1'b0;
        if (last_fire) pend_m[IssueRd] = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        int r;
        idle_inputs();
        model_reset();
        RST = 0;
        WbWre = 1; WbReg = 1; LuValid = 1; LuReg = 2; IssueValid = 1; IssueLong = 1;
        @(negedge CLK);
        #1 reset_check();
        @(negedge CLK);
        idle_inputs();
        RST = 1;
        step();

        // Bypass after issuing a long op to r7.
        IssueValid = 1; IssueLong = 1; IssueRd = 7;
        step();
        check("pend7_set", Pending[7], 1);
        idle_inputs();
        LuValid = 1; LuReg = 7; LuData = 32'hDEAD_BEEF;
        #1;
        check("bypass_we", RegWre, 1);
        check("bypass_reg", WriteReg, 7);
        check("bypass_data", WriteData, 32'hDEAD_BEEF);
        step();
        check("pend7_clr", Pending[7], 0);
        idle_inputs();

        // Contention: WB holds the port while LU results 3 and 4 queue up.
        WbWre = 1; WbReg = 1; WbData = 32'h1111;
        LuValid = 1; LuReg = 3; LuData = 32'h3333;
        step();
        LuReg = 4; LuData = 32'h4444;
        step();
        LuValid = 0;
        check("cont_count", FifoCount, 2);
        check("cont_ready", LuReady, 0);
        step();
        WbWre = 0;
        #1;
        check("order_first", WriteReg, 3);
        step();
        check("order_second", WriteReg, 4);
        step();
        check("drained", FifoCount, 0);

        // RAW/WAW against an outstanding LU destination.
        IssueValid = 1; IssueLong = 1; IssueRd = 5;
        step();
        check("pend5_set", Pending[5], 1);
        IssueLong = 0; IssueRs = 5; IssueRd = 9;
        #1 check("raw_stall", Stall, 1);
        step();
        IssueLong = 1; IssueRs = 0; IssueRd = 5;
        #1 check("waw_stall", Stall, 1);
        step();
        IssueLong = 0; IssueRs = 5; IssueRd = 9;
        LuValid = 1; LuReg = 5; LuData = 32'h5555;
        step();
        LuValid = 0;
        #1 check("raw_release", Stall, 0);
        step();
        idle_inputs();

        // Zero-destination LU result is consumed without a write.
        LuValid = 1; LuReg = 0; LuData = 32'hABCD;
        #1 check("zero_we", RegWre, 0);
        step();
        idle_inputs();

        // Full FIFO stalls a long issue until one entry drains.
        WbWre = 1; WbReg = 1; LuValid = 1; LuReg = 10; LuData = 32'hA;
        step();
        LuReg = 11; LuData = 32'hB;
        step();
        LuValid = 0;
        IssueValid = 1; IssueLong = 1; IssueRd = 12;
        #1 check("full_stall", Stall, 1);
        step();
        WbWre = 0;
        step();
        #1 check("full_release", Stall, 0);
        step();
        idle_inputs();
        step();

        // Reset while results are buffered and r12 is outstanding.
        WbWre = 1; WbReg = 2; LuValid = 1; LuReg = 13; LuData = 32'hD;
        step();
        LuReg = 14; LuData = 32'hE;
        step();
        check("pre_rst_count", FifoCount, 2);
        RST = 0;
        #1 reset_check();
        model_reset();
        @(negedge CLK);
        idle_inputs();
        RST = 1;
        #1 check("post_rst_ready", LuReady, 1);
        step();

        // Randomized traffic with an LU that returns results for issued long ops.
        for (int cyc = 0; cyc < 3200; cyc++) begin
            bit draining;
            draining = (cyc >= 3000);
            if (last_fire) lu_out.push_back(IssueRd);
            if (LuValid && last_xfer) LuValid = 0;
            if (!LuValid) begin
                if (lu_out.size() > 0 && $urandom_range(0, 2) == 0) begin
                    LuValid = 1; LuReg = lu_out.pop_front(); LuData = $urandom;
                end else if (!draining && $urandom_range(0, 15) == 0) begin
                    LuValid = 1; LuReg = 0; LuData = $urandom;
                end
            end
            IssueValid = !draining && ($urandom_range(0, 1) == 1);
            IssueLong  = ($urandom_range(0, 2) == 0);
            IssueRs    = 5'($urandom_range(0, 7));
            IssueRt    = 5'($urandom_range(0, 7));
            IssueRd    = 5'($urandom_range(0, 7));
            r = $urandom_range(0, 7);
            if (pend_m[r]) r = 0;
            WbWre  = !draining && ($urandom_range(0, 1) == 1);
            WbReg  = 5'(r);
            WbData = $urandom;
            step();
        end
        check("final_pending", Pending, 0);
        check("final_count", FifoCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
